mem_access_unit: RTL and testbench

- Front-end sequencer that sits directly upstream of the `memory` module.
- Arbitrates the single memory port between the instruction-fetch requester and the load/store requester.
- Drives `memory`'s address, data, `funct3` and `write_mem` inputs, and absorbs its 1-cycle registered read latency.
- Returns single-cycle response pulses to each requester and detects misaligned data accesses.

---
 rtl/mem_access_unit.sv | 76 +++++++
 tb/tb_mem_access_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: arbitrates fetch and load/store onto the single `memory` port and returns one-cycle response pulses.
// Define MISALIGN_CHECK_EN to fault misaligned word/half data accesses instead of forwarding them.
module mem_access_unit #(
  parameter logic [2:0] RESET_FUNCT3 = 3'b010
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic        fetch_ready,
  output logic        fetch_valid,
  output logic [31:0] fetch_instr,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [2:0]  ls_funct3,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_ready,
  output logic        ls_valid,
  output logic [31:0] ls_rdata,
  output logic        ls_misaligned,
  output logic        mem_write,
  output logic [2:0]  mem_funct3,
  output logic [31:0] mem_write_address,
  output logic [31:0] mem_write_data,
  output logic [31:0] mem_read_address,
  input  logic [31:0] mem_read_data
);
  typedef enum logic [1:0] {IDLE, FETCH_RSP, LOAD_RSP, ACK_RSP} state_e;
  state_e      state_q, state_d;
  logic        mis_q, misaligned, store_ok, load_ok;
  logic [31:0] instr_q, rdata_q, raddr_q, waddr_q, wdata_q;
  always_comb begin
`ifdef MISALIGN_CHECK_EN
    misaligned = (ls_funct3 == 3'b010 && ls_addr[1:0] != 2'b00) || (ls_funct3[1:0] == 2'b01 && ls_addr[0]);
`else
    misaligned = 1'b0;
`endif
  end
  // Readiness is gated by reset so nothing is accepted while rst_n is low.
  assign ls_ready    = rst_n & ls_req;
  assign fetch_ready = rst_n & fetch_req & ~ls_req;
  assign store_ok    = ls_ready & ls_we & ~misaligned;
  assign load_ok     = ls_ready & ~ls_we;
  assign mem_write         = store_ok;
  assign mem_funct3        = ls_ready ? ls_funct3 : fetch_ready ? 3'b010 : RESET_FUNCT3;
  assign mem_read_address  = load_ok ? ls_addr : fetch_ready ? fetch_addr : raddr_q;
  assign mem_write_address = store_ok ? ls_addr : waddr_q;
  assign mem_write_data    = store_ok ? ls_wdata : wdata_q;
  assign state_d = ls_ready ? ((ls_we || misaligned) ? ACK_RSP : LOAD_RSP) : fetch_ready ? FETCH_RSP : IDLE;
  assign fetch_valid   = state_q == FETCH_RSP;
  assign ls_valid      = state_q == LOAD_RSP || state_q == ACK_RSP;
  assign ls_misaligned = mis_q;
  // Read data arrives from `memory` during the response cycle, so it is passed straight through.
  assign fetch_instr = fetch_valid ? mem_read_data : instr_q;
  assign ls_rdata    = state_q == LOAD_RSP ? mem_read_data : state_q == ACK_RSP ? 32'd0 : rdata_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mis_q   <= 1'b0;
      instr_q <= '0;
      rdata_q <= '0;
      raddr_q <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      mis_q   <= ls_ready & misaligned;
      instr_q <= fetch_instr;
      rdata_q <= ls_rdata;
      raddr_q <= mem_read_address;
      waddr_q <= mem_write_address;
      wdata_q <= mem_write_data;
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: drives mem_access_unit against a behavioural `memory` and a reference model.
module tb_mem_access_unit;
  logic        clk = 0, rst_n = 0;
  logic        fetch_req = 0, ls_req = 0, ls_we = 0;
  logic [31:0] fetch_addr = 0, ls_addr = 0, ls_wdata = 0, mem_read_data = 0;
  logic [2:0]  ls_funct3 = 0;
  logic        fetch_ready, fetch_valid, ls_ready, ls_valid, ls_misaligned, mem_write;
  logic [31:0] fetch_instr, ls_rdata, mem_write_address, mem_write_data, mem_read_address;
  logic [2:0]  mem_funct3;

  mem_access_unit dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr),
    .ls_req(ls_req), .ls_we(ls_we), .ls_funct3(ls_funct3), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_ready(ls_ready), .ls_valid(ls_valid),
    .ls_rdata(ls_rdata), .ls_misaligned(ls_misaligned),
    .mem_write(mem_write), .mem_funct3(mem_funct3),
    .mem_write_address(mem_write_address), .mem_write_data(mem_write_data),
    .mem_read_address(mem_read_address), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  logic [7:0] dmem [0:1023];
  logic [7:0] rmem [0:1023];
  int tests = 0, fails = 0;
  logic        exp_fv = 0, exp_lv = 0, exp_lm = 0;
  logic [31:0] exp_fi = 0, exp_lr = 0, last_fi = 0, last_lr = 0;

  function automatic logic [31:0] rd(input bit r, input logic [31:0] a, input logic [2:0] f);
    logic [31:0] w;
    logic [9:0]  ix;
    for (int i = 0; i < 4; i++) begin
      ix = a[9:0] + 10'(i);
      w[8*i +: 8] = r ? rmem[ix] : dmem[ix];
    end
    case (f)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b100:  return {24'd0, w[7:0]};
      3'b101:  return {16'd0, w[15:0]};
      default: return w;
    endcase
  endfunction

  // Behavioural `memory`: registered read, synchronous byte/half/word write.
  always @(posedge clk) begin
    mem_read_data <= rd(0, mem_read_address, mem_funct3);
    if (mem_write)
      for (int i = 0; i < (mem_funct3[1:0] == 2'b00 ? 1 : mem_funct3[1:0] == 2'b01 ? 2 : 4); i++)
        dmem[mem_write_address[9:0] + 10'(i)] <= mem_write_data[8*i +: 8];
  end

  task automatic wr_ref(input logic [31:0] a, input logic [2:0] f, input logic [31:0] d);
    for (int i = 0; i < (f[1:0] == 2'b00 ? 1 : f[1:0] == 2'b01 ? 2 : 4); i++)
      rmem[a[9:0] + 10'(i)] = d[8*i +: 8];
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_rsp();
    chk("fetch_valid", fetch_valid, exp_fv);
    chk("fetch_instr", fetch_instr, exp_fi);
    chk("ls_valid", ls_valid, exp_lv);
    chk("ls_misaligned", ls_misaligned, exp_lm);
    chk("ls_rdata", ls_rdata, exp_lr);
    last_fi = exp_fi;
    last_lr = exp_lr;
  endtask

  task automatic apply(input bit fr, input logic [31:0] fa, input bit lr, input bit we,
                       input logic [2:0] f3, input logic [31:0] la, input logic [31:0] wd);
    bit mis;
    fetch_req = fr; fetch_addr = fa; ls_req = lr; ls_we = we;
    ls_funct3 = f3; ls_addr = la; ls_wdata = wd;
    #1;
    mis = 0;
`ifdef MISALIGN_CHECK_EN
    mis = (f3 == 3'b010 && la[1:0] != 2'b00) || (f3[1:0] == 2'b01 && la[0]);
`endif
    chk("ls_ready", ls_ready, lr);
    chk("fetch_ready", fetch_ready, fr && !lr);
    chk("mem_write", mem_write, lr && we && !mis);
    chk("mem_funct3", mem_funct3, lr ? f3 : 3'b010);
    exp_fv = 0; exp_lv = 0; exp_lm = 0; exp_fi = last_fi; exp_lr = last_lr;
    if (lr) begin
      exp_lv = 1;
      if (mis) begin
        exp_lm = 1; exp_lr = 0;
      end else if (we) begin
        chk("mem_write_address", mem_write_address, la);
        chk("mem_write_data", mem_write_data, wd);
        wr_ref(la, f3, wd);
        exp_lr = 0;
      end else begin
        chk("mem_read_address", mem_read_address, la);
        exp_lr = rd(1, la, f3);
      end
    end else if (fr) begin
      chk("mem_read_address", mem_read_address, fa);
      exp_fv = 1;
      exp_fi = rd(1, fa, 3'b010);
    end
  endtask

  task automatic step(input bit fr, input logic [31:0] fa, input bit lr, input bit we,
                      input logic [2:0] f3, input logic [31:0] la, input logic [31:0] wd);
    check_rsp();
    apply(fr, fa, lr, we, f3, la, wd);
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 3'b000, 0, 0);
  endtask

  typedef struct {
    logic fr, lr, we; logic [2:0] f3; logic [31:0] la, fa;
    logic efr, elr, ew; logic [2:0] ef3;
  } vec_t;
  vec_t tv [8];

  initial begin
    bit pf;
    logic [31:0] pfa, la;
    logic [2:0] f3;
    logic [2:0] f3s [5];
    f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    for (int i = 0; i < 1024; i++) begin
      dmem[i] = 8'($urandom);
      rmem[i] = dmem[i];
    end
    {dmem[7], dmem[6], dmem[5], dmem[4]} = 32'h00500093;
    {dmem[259], dmem[258], dmem[257], dmem[256]} = 32'hDEADBEEF;
    for (int i = 0; i < 1024; i++) rmem[i] = dmem[i];
    tv[0] = '{0, 0, 0, 3'b000, 32'h0,   32'h0,  0, 0, 0, 3'b010};
    tv[1] = '{1, 0, 0, 3'b000, 32'h0,   32'h10, 1, 0, 0, 3'b010};
    tv[2] = '{0, 1, 0, 3'b000, 32'h105, 32'h0,  0, 1, 0, 3'b000};
    tv[3] = '{1, 1, 0, 3'b101, 32'h106, 32'h14, 0, 1, 0, 3'b101};
    tv[4] = '{1, 1, 1, 3'b010, 32'h110, 32'h18, 0, 1, 1, 3'b010};
    tv[5] = '{0, 1, 1, 3'b001, 32'h112, 32'h0,  0, 1, 1, 3'b001};
    tv[6] = '{1, 1, 0, 3'b100, 32'h111, 32'h1c, 0, 1, 0, 3'b100};
    tv[7] = '{0, 1, 0, 3'b111, 32'h114, 32'h0,  0, 1, 0, 3'b111};

    // Reset state with both requests asserted.
    fetch_req = 1; ls_req = 1; ls_we = 1;
    #2;
    chk("rst_fetch_ready", fetch_ready, 0);
    chk("rst_ls_ready", ls_ready, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_funct3", mem_funct3, 3'b010);
    chk("rst_mem_read_address", mem_read_address, 0);
    chk("rst_mem_write_address", mem_write_address, 0);
    chk("rst_mem_write_data", mem_write_data, 0);
    chk("rst_valids", {fetch_valid, ls_valid, ls_misaligned}, 0);
    chk("rst_fetch_instr", fetch_instr, 0);
    chk("rst_ls_rdata", ls_rdata, 0);
    fetch_req = 0; ls_req = 0; ls_we = 0;
    @(negedge clk); @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < 8; i++) begin
      check_rsp();
      apply(tv[i].fr, tv[i].fa, tv[i].lr, tv[i].we, tv[i].f3, tv[i].la, 32'h1234_5678 + i);
      chk("tv_fetch_ready", fetch_ready, tv[i].efr);
      chk("tv_ls_ready", ls_ready, tv[i].elr);
      chk("tv_mem_write", mem_write, tv[i].ew);
      chk("tv_mem_funct3", mem_funct3, tv[i].ef3);
      @(negedge clk);
    end
    idle();

    step(1, 32'h4, 0, 0, 3'b000, 0, 0);
    chk("fetch_4", fetch_instr, 32'h00500093);
    step(1, 32'h8, 1, 0, 3'b010, 32'h100, 0);
    chk("load_deadbeef", ls_rdata, 32'hDEADBEEF);
    step(1, 32'h8, 0, 0, 3'b000, 0, 0);
    idle();

    step(0, 0, 1, 1, 3'b000, 32'h103, 32'hFFFF_FFA5);
    step(0, 0, 1, 0, 3'b000, 32'h103, 0);
    chk("lb_a5", ls_rdata, 32'hFFFFFFA5);
    step(0, 0, 1, 1, 3'b000, 32'h103, 32'h0000_00A5);
    step(0, 0, 1, 0, 3'b100, 32'h103, 0);
    chk("lbu_a5", ls_rdata, 32'h000000A5);
    idle();

    step(0, 0, 1, 1, 3'b010, 32'h102, 32'h1111_2222);
`ifdef MISALIGN_CHECK_EN
    chk("mis_flag", ls_misaligned, 1);
`endif
    step(0, 0, 1, 0, 3'b010, 32'h100, 0);
    idle();

    step(1, 32'h0, 0, 0, 3'b000, 0, 0);
    step(1, 32'h4, 0, 0, 3'b000, 0, 0);
    step(1, 32'h8, 0, 0, 3'b000, 0, 0);
    idle();
    idle();

    // Reset while a load response is outstanding.
    step(0, 0, 1, 0, 3'b010, 32'h100, 0);
    rst_n = 0;
    #1;
    chk("rst_ls_valid", ls_valid, 0);
    chk("rst_ls_rdata_mid", ls_rdata, 0);
    exp_fv = 0; exp_lv = 0; exp_lm = 0; exp_fi = 0; exp_lr = 0;
    @(negedge clk);
    rst_n = 1;
    idle();
    idle();

    pf = 0; pfa = 0;
    for (int n = 0; n < 400; n++) begin
      if (!pf && $urandom_range(0, 9) < 6) begin
        pf = 1;
        pfa = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      end
      f3 = f3s[$urandom_range(0, 4)];
      la = 32'h100 + 32'($urandom_range(0, 31));
`ifndef MISALIGN_CHECK_EN
      if (f3[1:0] == 2'b01) la[0] = 1'b0;
      if (f3 == 3'b010) la[1:0] = 2'b00;
`endif
      step(pf, pfa, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), f3, la, $urandom);
      if (pf && !ls_req) pf = 0;
    end
    idle();
    check_rsp();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
